// File: rtl/or_n_filtered.sv
// N-input OR combiner: per-input synchroniser and glitch filter, then mask, OR-reduce and register.
// Define OR_STICKY_EN to build the per-channel sticky source capture (src/clr); otherwise src reads 0.
module or_n_filtered #(
    parameter int N_IN        = 2,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_IN-1:0] din,
    input  logic [N_IN-1:0] mask,
    input  logic            clr,
    output logic            dout,
    output logic            dout_rise,
    output logic            dout_fall,
    output logic [N_IN-1:0] src
);

    logic [N_IN-1:0] sync_q [SYNC_STAGES];
    logic [N_IN-1:0] s_w;
    logic [N_IN-1:0] f_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= din;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    assign s_w = sync_q[SYNC_STAGES-1];

    generate
        if (FILT_CYCLES > 0) begin : g_filt
            localparam int CW = $clog2(FILT_CYCLES + 1);
            localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYCLES - 1);

            logic [N_IN-1:0] filt_q, filt_d;
            logic [CW-1:0]   cnt_q [N_IN];
            logic [CW-1:0]   cnt_d [N_IN];

            // A level change is accepted only after FILT_CYCLES consecutive disagreeing samples.
            always_comb begin
                filt_d = filt_q;
                for (int i = 0; i < N_IN; i++) begin
                    cnt_d[i] = '0;
                    if (s_w[i] != filt_q[i]) begin
                        if (cnt_q[i] == CNT_LAST) filt_d[i] = ~filt_q[i];
                        else                      cnt_d[i]  = cnt_q[i] + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    filt_q <= '0;
                    for (int i = 0; i < N_IN; i++) cnt_q[i] <= '0;
                end else begin
                    filt_q <= filt_d;
                    for (int i = 0; i < N_IN; i++) cnt_q[i] <= cnt_d[i];
                end
            end

            assign f_w = filt_q;
        end else begin : g_bypass
            assign f_w = s_w;
        end
    endgenerate

    logic dout_q, dout_d;
    logic rise_q, rise_d;
    logic fall_q, fall_d;

    assign dout_d = |(f_w & mask);
    assign rise_d = ~dout_q & dout_d;
    assign fall_d = dout_q & ~dout_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            dout_q <= dout_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign dout      = dout_q;
    assign dout_rise = rise_q;
    assign dout_fall = fall_q;

`ifdef OR_STICKY_EN
    logic [N_IN-1:0] src_q, src_d;

    // Set term is OR-ed after the clear so a same-cycle set is never lost.
    assign src_d = (src_q & ~{N_IN{clr}}) | (f_w & mask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) src_q <= '0;
        else        src_q <= src_d;
    end

    assign src = src_q;
`else
    logic unused_clr;
    assign unused_clr = clr;
    assign src        = '0;
`endif

endmodule

// File: tb/tb_or_n_filtered.sv
// Directed bench for or_n_filtered: cycle model feeds an expectation queue, plus a filter-bypass instance.
module tb_or_n_filtered;

    localparam int N  = 2;
    localparam int SS = 2;
    localparam int FC = 4;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] din, mask, src;
    logic         clr, dout, dout_rise, dout_fall;

    logic [7:0]   din8, mask8, src8;
    logic         clr8, dout8, rise8, fall8;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic         dout;
        logic         rise;
        logic         fall;
        logic [N-1:0] src;
    } exp_t;

    exp_t exp_q[$];

    logic [N-1:0]  m_sync [SS];
    logic [N-1:0]  m_f, m_src;
    logic          m_dout;
    logic [FC-1:0] m_win [N];

    int hi_cnt, rise_cnt, fall_cnt;

    or_n_filtered #(.N_IN(N), .SYNC_STAGES(SS), .FILT_CYCLES(FC)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .mask(mask), .clr(clr),
        .dout(dout), .dout_rise(dout_rise), .dout_fall(dout_fall), .src(src)
    );

    or_n_filtered #(.N_IN(8), .SYNC_STAGES(3), .FILT_CYCLES(0)) dut8 (
        .clk(clk), .rst_n(rst_n), .din(din8), .mask(mask8), .clr(clr8),
        .dout(dout8), .dout_rise(rise8), .dout_fall(fall8), .src(src8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < SS; k++) m_sync[k] = '0;
        for (int c = 0; c < N; c++) m_win[c] = '0;
        m_f    = '0;
        m_src  = '0;
        m_dout = 1'b0;
    endtask

    // One clock edge: predict, push, advance, pop, compare.
    task automatic step();
        exp_t         e, got;
        logic [N-1:0] s_old, f_old;
        logic         dn;
        e = '0;
        if (!rst_n) begin
            model_reset();
        end else begin
            s_old  = m_sync[SS-1];
            f_old  = m_f;
            dn     = |(f_old & mask);
            e.dout = dn;
            e.rise = ~m_dout & dn;
            e.fall = m_dout & ~dn;
`ifdef OR_STICKY_EN
            e.src  = (m_src & ~{N{clr}}) | (f_old & mask);
`else
            e.src  = '0;
`endif
            m_dout = dn;
            m_src  = e.src;
            for (int c = 0; c < N; c++) begin
                m_win[c] = {m_win[c][FC-2:0], s_old[c]};
                if (m_win[c] == {FC{~f_old[c]}}) m_f[c] = ~f_old[c];
            end
            for (int k = SS - 1; k > 0; k--) m_sync[k] = m_sync[k-1];
            m_sync[0] = din;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("queue_empty", 32'd0, 32'd1);
        end else begin
            got = exp_q.pop_front();
            check("dout", 32'(dout), 32'(got.dout));
            check("dout_rise", 32'(dout_rise), 32'(got.rise));
            check("dout_fall", 32'(dout_fall), 32'(got.fall));
            check("src", 32'(src), 32'(got.src));
        end
        if (dout)      hi_cnt++;
        if (dout_rise) rise_cnt++;
        if (dout_fall) fall_cnt++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_tallies();
        hi_cnt   = 0;
        rise_cnt = 0;
        fall_cnt = 0;
    endtask

    initial begin
        int           lat;
        logic         r8;
        logic [7:0]   s8;
        logic [N-1:0] exp_src;

        rst_n = 1'b0;
        din   = '0;
        mask  = 2'b11;
        clr   = 1'b0;
        din8  = '0;
        mask8 = 8'hFF;
        clr8  = 1'b0;
        model_reset();
        clear_tallies();
        #1;
        check("reset_dout", 32'(dout), 32'd0);
        check("reset_pulses", 32'({dout_rise, dout_fall}), 32'd0);
        check("reset_src", 32'(src), 32'd0);
        check("reset_dout8", 32'(dout8), 32'd0);
        run(3);
        rst_n = 1'b1;
        run(2);

        // Filter bypass instance: 3 sync flops then the output register.
        din8 = 8'h80;
        lat  = 0;
        r8   = 1'b0;
        s8   = '0;
        for (int n = 1; n <= 10; n++) begin
            step();
            if (dout8 && lat == 0) begin
                lat = n;
                r8  = rise8;
                s8  = src8;
            end
        end
        check("bypass_latency", 32'(lat), 32'd4);
        check("bypass_rise", 32'(r8), 32'd1);
`ifdef OR_STICKY_EN
        check("bypass_src", 32'(s8), 32'h80);
`else
        check("bypass_src", 32'(s8), 32'h00);
`endif
        din8 = '0;

        // Default latency from a held level change.
        clear_tallies();
        din = 2'b01;
        lat = 0;
        for (int n = 1; n <= 12; n++) begin
            step();
            if (dout && lat == 0) lat = n;
        end
        check("latency", 32'(lat), 32'd7);
        check("single_rise", 32'(rise_cnt), 32'd1);
        check("no_fall", 32'(fall_cnt), 32'd0);
        din = 2'b00;
        run(10);

        // Three-cycle pulse is rejected; four-cycle pulse passes intact.
        clear_tallies();
        din = 2'b01;
        run(3);
        din = 2'b00;
        run(12);
        check("glitch_hi", 32'(hi_cnt), 32'd0);
        check("glitch_rise", 32'(rise_cnt), 32'd0);
        check("glitch_src", 32'(src), 32'd0);
        clear_tallies();
        din = 2'b01;
        run(4);
        din = 2'b00;
        run(12);
        check("pulse4_hi", 32'(hi_cnt), 32'd4);
        check("pulse4_rise", 32'(rise_cnt), 32'd1);
        check("pulse4_fall", 32'(fall_cnt), 32'd1);

        // Masking off the active channel, then back on.
        din = 2'b10;
        run(8);
        mask = 2'b01;
        step();
        check("mask_off_dout", 32'(dout), 32'd0);
        check("mask_off_fall", 32'(dout_fall), 32'd1);
        mask = 2'b11;
        step();
        check("mask_on_rise", 32'(dout_rise), 32'd1);

        // Sticky capture: persists, clears, and a set beats a concurrent clear.
        din = 2'b00;
        run(8);
        clr = 1'b1;
        step();
        clr = 1'b0;
        run(2);
        check("clr_src", 32'(src), 32'd0);
        din = 2'b10;
        run(6);
        din = 2'b00;
        run(12);
`ifdef OR_STICKY_EN
        exp_src = 2'b10;
`else
        exp_src = 2'b00;
`endif
        check("sticky_hold", 32'(src), 32'(exp_src));
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("sticky_clr", 32'(src), 32'd0);
        din = 2'b10;
        run(8);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_vs_set", 32'(src), 32'(exp_src));

        // Asynchronous reset mid-filter with dout high.
        din = 2'b01;
        run(8);
        din = 2'b00;
        run(4);
        check("pre_reset_dout", 32'(dout), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_dout", 32'(dout), 32'd0);
        check("async_pulses", 32'({dout_rise, dout_fall}), 32'd0);
        check("async_src", 32'(src), 32'd0);
        model_reset();
        #1;
        rst_n = 1'b1;
        din   = 2'b01;
        clear_tallies();
        lat = 0;
        for (int n = 1; n <= 12; n++) begin
            step();
            if (dout && lat == 0) lat = n;
        end
        check("post_reset_latency", 32'(lat), 32'd7);
        check("post_reset_fall", 32'(fall_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/or_n_filtered.md
Name: or_n_filtered

Overview:
- Parametrised, registered N-input OR combiner for asynchronous line/event inputs, e.g. PS/2 clock/data activity flags and keyboard status events.
- Each input is synchronised and glitch-filtered before masking and OR-reduction.
- Produces a registered OR output, one-cycle rise/fall pulses and a per-input sticky source capture.
- Sits between raw pad-level/asynchronous event sources and the PS/2 receive/control logic.

Parameters:
N_IN, 2, number of input channels (1..32)
SYNC_STAGES, 2, synchroniser flops per input (>=2)
FILT_CYCLES, 4, consecutive stable synced cycles required to accept a level change; 0 = filter bypass

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous, active-low reset
din  input  N_IN  asynchronous input lines
mask  input  N_IN  synchronous per-channel enable, 1 = channel participates
clr  input  1  synchronous clear of sticky capture
dout  output  1  registered OR of filtered, masked inputs
dout_rise  output  1  one-cycle pulse on dout 0->1
dout_fall  output  1  one-cycle pulse on dout 1->0
src  output  N_IN  sticky record of channels that contributed a 1

Behaviour:
- Reset (rst_n=0, asynchronous): all sync flops, filtered levels f[i], filter counters, dout, dout_rise, dout_fall and src = 0. Release is synchronous to clk (next edge after deassertion acts normally).
- Sync: s[i] = din[i] delayed by SYNC_STAGES flops.
- Filter, per channel, FILT_CYCLES>0:
  - counter cnt[i], width clog2(FILT_CYCLES+1).
  - If s[i]==f[i]: cnt cleared.
  - If s[i]!=f[i] and cnt==FILT_CYCLES-1: f[i] toggles, cnt cleared.
  - Otherwise cnt increments.
  - A synced pulse shorter than FILT_CYCLES cycles never changes f[i].
- Filter bypass, FILT_CYCLES=0: f[i]=s[i] combinationally.
- Output: dout_next = |(f & mask); dout registered.
  - dout_rise = ~dout & dout_next, registered alongside dout; dout_fall likewise.
  - Rise and fall pulses are never both 1.
- Latency din->dout: SYNC_STAGES+FILT_CYCLES+1 clk edges (defaults: 7).
- Mask change reaches dout on the next edge and may itself produce a rise/fall pulse.
- Sticky (see feature): src[i] <= (src[i] & ~clr) | (f[i] & mask[i]). Simultaneous clr and set: set wins, no event lost.
- Reset mid-filter: partial counts are discarded; no pulse is emitted on reset or its release.
- N_IN=1: acts as a single-line filtered register.

Optional Feature:
OR_STICKY_EN
- Defined: src/clr behave as specified.
- Undefined: src tied to 0, clr ignored, no sticky flops synthesised.
- Port list is identical in both builds.

Test Plan:
1. Reset then defaults: din=2'b01, mask=2'b11 held -> dout=1 and dout_rise=1 for exactly one cycle at edge 7 after change; dout_fall stays 0.
2. Glitch reject: din[0] high for 3 cycles (FILT_CYCLES=4) -> dout, dout_rise, src all remain 0. Repeat with a 4-cycle pulse -> dout high for 4 cycles, single rise and fall pulses.
3. Masking: din=2'b10 steady, dout=1; set mask=2'b01 -> dout=0 next edge with dout_fall=1; restore mask -> dout_rise=1 next edge.
4. Sticky (OR_STICKY_EN): din[1] pulse of 6 cycles -> src=2'b10 persists after din drops. Pulse clr=1 -> src=0. clr asserted while f[1]=1 -> src[1] stays 1.
5. Async reset mid-operation: rst_n low for half a cycle while dout=1 and cnt[0]=2 -> dout, src, pulses 0 immediately. After release with din steady high, full 7-cycle latency reapplies.
6. FILT_CYCLES=0, N_IN=8, SYNC_STAGES=3: din=8'h80 -> dout=1 at edge 4; build without OR_STICKY_EN -> src=0 throughout.
